// File: rtl/sal_ddr_sched_pkg.sv
// Shared command encoding, DFI decode helper and timing defaults for the SAL DDR command scheduler.
package sal_ddr_sched_pkg;

  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;

  localparam int DEF_BK_CNT  = 8;
  localparam int DEF_ADDR_W  = 14;
  localparam int DEF_T_RRD   = 2;
  localparam int DEF_T_FAW   = 10;
  localparam int DEF_T_CCD   = 2;
  localparam int DEF_T_REFI  = 780;
  localparam int DEF_T_RFC   = 26;
  localparam int DEF_REF_OWE = 8;

  // Returns {ras_n, cas_n, we_n} for a command; anything unknown decodes as NOP.
  function automatic logic [2:0] cmd2dfi(input cmd_t c);
    logic [2:0] v;
    case (c)
      CMD_ACT: v = 3'b011;
      CMD_RD:  v = 3'b101;
      CMD_WR:  v = 3'b100;
      CMD_PRE: v = 3'b010;
      CMD_REF: v = 3'b001;
      default: v = 3'b111;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/sal_faw_tracker.sv
// Four-activate window tracker: one down-counter per recent ACT, ACT allowed while a slot is free.
module sal_faw_tracker
  import sal_ddr_sched_pkg::*;
#(
  parameter int T_FAW = DEF_T_FAW
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_act,
  output logic o_act_ok
);

  localparam int FAW_W = $clog2(T_FAW + 1);

  logic [FAW_W-1:0] r_slot [4];
  logic [1:0]       w_free;
  logic [2:0]       w_busy;
  logic             w_have_free;

  // Count occupied slots and pick the lowest free one for the next ACT.
  always_comb begin
    w_busy      = 3'd0;
    w_free      = 2'd0;
    w_have_free = 1'b0;
    for (int s = 0; s < 4; s++) begin
      w_busy      = w_busy + ((r_slot[s] != '0) ? 3'd1 : 3'd0);
      w_free      = (!w_have_free && (r_slot[s] == '0)) ? 2'(s) : w_free;
      w_have_free = w_have_free | (r_slot[s] == '0);
    end
    o_act_ok = (w_busy < 3'd4);
  end

  // Slot counters: load on ACT, otherwise count down to zero.
  always_ff @(posedge i_clk) begin
    for (int s = 0; s < 4; s++) begin
      if (i_rst) begin
        r_slot[s] <= '0;
      end else if (i_act && w_have_free && (w_free == 2'(s))) begin
        r_slot[s] <= FAW_W'(T_FAW - 1);
      end else if (r_slot[s] != '0) begin
        r_slot[s] <= r_slot[s] - FAW_W'(1);
      end else begin
        r_slot[s] <= r_slot[s];
      end
    end
  end

endmodule

// File: rtl/sal_ddr_cmd_sched.sv
// Round-robin DRAM command scheduler with inter-bank timing, periodic refresh and one registered DFI command per cycle.
module sal_ddr_cmd_sched
  import sal_ddr_sched_pkg::*;
#(
  parameter int BK_CNT  = DEF_BK_CNT,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int T_RRD   = DEF_T_RRD,
  parameter int T_FAW   = DEF_T_FAW,
  parameter int T_CCD   = DEF_T_CCD,
  parameter int T_REFI  = DEF_T_REFI,
  parameter int T_RFC   = DEF_T_RFC,
  parameter int REF_OWE = DEF_REF_OWE
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [BK_CNT-1:0]           i_bk_req_valid,
  input  logic [BK_CNT*3-1:0]         i_bk_req_cmd,
  input  logic [BK_CNT*ADDR_W-1:0]    i_bk_req_addr,
  input  logic [BK_CNT-1:0]           i_bk_idle,
  output logic [BK_CNT-1:0]           o_bk_gnt,
  output logic                        o_ref_req,
  output logic                        o_ref_overflow,
  output logic                        o_dfi_cs_n,
  output logic                        o_dfi_ras_n,
  output logic                        o_dfi_cas_n,
  output logic                        o_dfi_we_n,
  output logic [$clog2(BK_CNT)-1:0]   o_dfi_bank,
  output logic [ADDR_W-1:0]           o_dfi_address
);

  localparam int BK_W   = $clog2(BK_CNT);
  localparam int RRD_W  = $clog2(T_RRD + 1);
  localparam int CCD_W  = $clog2(T_CCD + 1);
  localparam int RFC_W  = $clog2(T_RFC + 1);
  localparam int REFI_W = $clog2(T_REFI + 1);
  localparam int OWE_W  = $clog2(REF_OWE + 1);

  logic [RRD_W-1:0]  r_trrd;
  logic [CCD_W-1:0]  r_tccd;
  logic [RFC_W-1:0]  r_trfc;
  logic [REFI_W-1:0] r_refi;
  logic [OWE_W-1:0]  r_owed;
  logic              r_ref_req;
  logic              r_ref_overflow;
  logic [BK_W-1:0]   r_ptr;

  logic [BK_CNT-1:0] w_elig;
  cmd_t              w_bcmd;
  cmd_t              w_win_cmd;
  logic [BK_W-1:0]   w_idx;
  logic [BK_W-1:0]   w_win;
  logic              w_found;
  logic              w_take;
  logic              w_act_ok;
  logic              w_ref_go;
  logic              w_gnt_go;
  logic              w_is_act;
  logic              w_is_cas;
  logic              w_refi_exp;
  logic [OWE_W-1:0]  w_owed_nxt;
  logic              w_ovf_set;

  sal_faw_tracker #(.T_FAW(T_FAW)) u_faw (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_act    (w_is_act),
    .o_act_ok (w_act_ok)
  );

  // Per-bank eligibility from the requested command and the shared timers.
  always_comb begin
    w_elig = '0;
    w_bcmd = CMD_NOP;
    for (int b = 0; b < BK_CNT; b++) begin
      w_bcmd = cmd_t'(i_bk_req_cmd[b*3 +: 3]);
      case (w_bcmd)
        CMD_ACT:         w_elig[b] = (r_trrd == '0) && w_act_ok && !r_ref_req;
        CMD_RD, CMD_WR:  w_elig[b] = (r_tccd == '0);
        CMD_PRE:         w_elig[b] = 1'b1;
        default:         w_elig[b] = 1'b0;
      endcase
      w_elig[b] = w_elig[b] && i_bk_req_valid[b] && (r_trfc == '0);
    end
  end

  // Round-robin pick starting at the pointer; refresh pre-empts every bank grant.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    w_take  = 1'b0;
    for (int i = 0; i < BK_CNT; i++) begin
      w_idx   = r_ptr + BK_W'(i);
      w_take  = !w_found && w_elig[w_idx];
      w_win   = w_take ? w_idx : w_win;
      w_found = w_found | w_take;
    end
    w_ref_go   = r_ref_req && (&i_bk_idle) && (r_trfc == '0) && !i_rst;
    w_gnt_go   = w_found && !w_ref_go && !i_rst;
    w_win_cmd  = cmd_t'(i_bk_req_cmd[w_win*3 +: 3]);
    w_is_act   = w_gnt_go && (w_win_cmd == CMD_ACT);
    w_is_cas   = w_gnt_go && ((w_win_cmd == CMD_RD) || (w_win_cmd == CMD_WR));
    o_bk_gnt   = w_gnt_go ? (BK_CNT'(1) << w_win) : '0;
    w_refi_exp = (r_refi == '0);
    w_ovf_set  = w_refi_exp && !w_ref_go && (r_owed == OWE_W'(REF_OWE));
    case ({w_refi_exp, w_ref_go})
      2'b10:   w_owed_nxt = (r_owed == OWE_W'(REF_OWE)) ? r_owed : r_owed + OWE_W'(1);
      2'b01:   w_owed_nxt = r_owed - OWE_W'(1);
      default: w_owed_nxt = r_owed;
    endcase
  end

  // Timing counters, refresh bookkeeping and arbitration pointer.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_trrd         <= '0;
      r_tccd         <= '0;
      r_trfc         <= '0;
      r_refi         <= REFI_W'(T_REFI - 1);
      r_owed         <= '0;
      r_ref_req      <= 1'b0;
      r_ref_overflow <= 1'b0;
      r_ptr          <= '0;
    end else begin
      r_trrd         <= w_is_act ? RRD_W'(T_RRD - 1) : ((r_trrd != '0) ? r_trrd - RRD_W'(1) : r_trrd);
      r_tccd         <= w_is_cas ? CCD_W'(T_CCD - 1) : ((r_tccd != '0) ? r_tccd - CCD_W'(1) : r_tccd);
      r_trfc         <= w_ref_go ? RFC_W'(T_RFC - 1) : ((r_trfc != '0) ? r_trfc - RFC_W'(1) : r_trfc);
      r_refi         <= w_refi_exp ? REFI_W'(T_REFI - 1) : r_refi - REFI_W'(1);
      r_owed         <= w_owed_nxt;
      r_ref_req      <= (w_owed_nxt != '0);
      r_ref_overflow <= r_ref_overflow | w_ovf_set;
      r_ptr          <= w_gnt_go ? w_win + BK_W'(1) : r_ptr;
    end
  end

  // DFI command register; bank and address hold across NOP and REF.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dfi_cs_n                              <= 1'b1;
      {o_dfi_ras_n, o_dfi_cas_n, o_dfi_we_n}  <= 3'b111;
      o_dfi_bank                              <= '0;
      o_dfi_address                           <= '0;
    end else if (w_ref_go) begin
      o_dfi_cs_n                              <= 1'b0;
      {o_dfi_ras_n, o_dfi_cas_n, o_dfi_we_n}  <= cmd2dfi(CMD_REF);
    end else if (w_gnt_go) begin
      o_dfi_cs_n                              <= 1'b0;
      {o_dfi_ras_n, o_dfi_cas_n, o_dfi_we_n}  <= cmd2dfi(w_win_cmd);
      o_dfi_bank                              <= w_win;
      o_dfi_address                           <= i_bk_req_addr[w_win*ADDR_W +: ADDR_W];
    end else begin
      o_dfi_cs_n                              <= 1'b0;
      {o_dfi_ras_n, o_dfi_cas_n, o_dfi_we_n}  <= 3'b111;
    end
  end

  assign o_ref_req      = r_ref_req;
  assign o_ref_overflow = r_ref_overflow;

endmodule

// File: tb/tb_sal_ddr_cmd_sched.sv
// Directed bench for sal_ddr_cmd_sched: reset, tRRD, tFAW, tCCD round-robin, refresh pre-emption and owed overflow.
module tb_sal_ddr_cmd_sched;
  import sal_ddr_sched_pkg::*;

  localparam int BK = 8;
  localparam int AW = 14;

  logic              clk = 1'b0;
  logic              rst;
  logic [BK-1:0]     valid;
  logic [BK*3-1:0]   cmd;
  logic [BK*AW-1:0]  addr;
  logic [BK-1:0]     idle;
  logic [BK-1:0]     gnt;
  logic              ref_req, ref_ovf;
  logic              cs_n, ras_n, cas_n, we_n;
  logic [2:0]        dbank;
  logic [AW-1:0]     daddr;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_win [0:31];

  always #5 clk = ~clk;

  sal_ddr_cmd_sched #(
    .BK_CNT(BK), .ADDR_W(AW), .T_RRD(2), .T_FAW(10), .T_CCD(2),
    .T_REFI(100), .T_RFC(26), .REF_OWE(8)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_bk_req_valid (valid),
    .i_bk_req_cmd   (cmd),
    .i_bk_req_addr  (addr),
    .i_bk_idle      (idle),
    .o_bk_gnt       (gnt),
    .o_ref_req      (ref_req),
    .o_ref_overflow (ref_ovf),
    .o_dfi_cs_n     (cs_n),
    .o_dfi_ras_n    (ras_n),
    .o_dfi_cas_n    (cas_n),
    .o_dfi_we_n     (we_n),
    .o_dfi_bank     (dbank),
    .o_dfi_address  (daddr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int b, input cmd_t c);
    valid[b]          = 1'b1;
    cmd[b*3 +: 3]     = c;
    addr[b*AW +: AW]  = AW'(32'h100 + b);
  endtask

  task automatic reset_dut();
    rst   = 1'b1;
    valid = '0;
    idle  = '1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    for (int i = 0; i < 32; i++) exp_win[i] = -1;
  endtask

  task automatic run_seq(input string tag, input int ncyc, input logic [2:0] rcw, input bit retire);
    logic [BK-1:0] g;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      check($sformatf("%s_gnt_c%0d", tag, c), gnt, (exp_win[c] < 0) ? 32'd0 : (32'd1 << exp_win[c]));
      if (c > 0) begin
        if (exp_win[c-1] >= 0) begin
          check($sformatf("%s_dfi_c%0d", tag, c), {cs_n, ras_n, cas_n, we_n}, {1'b0, rcw});
          check($sformatf("%s_bank_c%0d", tag, c), dbank, exp_win[c-1]);
          check($sformatf("%s_addr_c%0d", tag, c), daddr, 32'h100 + exp_win[c-1]);
        end else begin
          check($sformatf("%s_nop_c%0d", tag, c), {cs_n, ras_n, cas_n, we_n}, 4'b0111);
        end
      end
      g = gnt;
      @(posedge clk); #1;
      if (retire) valid = valid & ~g;
    end
  endtask

  initial begin
    bit done;
    rst   = 1'b1;
    idle  = '1;
    valid = '0;
    cmd   = '0;
    addr  = '0;
    for (int b = 0; b < BK; b++) set_req(b, CMD_ACT);

    // Test 1: reset held with requests active
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_gnt", gnt, 32'd0);
      check("rst_dfi", {cs_n, ras_n, cas_n, we_n}, 4'b1111);
      check("rst_refreq", ref_req, 32'd0);
      check("rst_ovf", ref_ovf, 32'd0);
      check("rst_bank_addr", {dbank, daddr}, 32'd0);
      @(posedge clk); #1;
    end
    rst   = 1'b0;
    valid = '0;
    @(negedge clk);
    check("rst_dfi_after_release", {cs_n, ras_n, cas_n, we_n}, 4'b1111);
    @(posedge clk); #1;

    // Test 2: two ACTs separated by tRRD
    reset_dut();
    set_req(0, CMD_ACT);
    set_req(1, CMD_ACT);
    exp_win[0] = 0;
    exp_win[2] = 1;
    run_seq("trrd", 5, 3'b011, 1'b1);

    // Test 3: five ACTs, fifth held off by the tFAW window
    reset_dut();
    for (int b = 0; b < 5; b++) set_req(b, CMD_ACT);
    exp_win[0]  = 0;
    exp_win[2]  = 1;
    exp_win[4]  = 2;
    exp_win[6]  = 3;
    exp_win[10] = 4;
    run_seq("tfaw", 12, 3'b011, 1'b1);

    // Test 4: continuous RDs rotate round-robin at tCCD spacing
    reset_dut();
    set_req(0, CMD_RD);
    set_req(3, CMD_RD);
    set_req(5, CMD_RD);
    exp_win[0] = 0;
    exp_win[2] = 3;
    exp_win[4] = 5;
    exp_win[6] = 0;
    run_seq("tccd", 8, 3'b101, 1'b0);
    valid = '0;

    // Test 5: refresh pre-empts ACT, waits for PRE, then holds off for tRFC
    reset_dut();
    repeat (99) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ref_req_c99", ref_req, 32'd0);
    @(posedge clk); #1;
    set_req(2, CMD_PRE);
    set_req(4, CMD_ACT);
    idle[2] = 1'b0;
    @(negedge clk);
    check("ref_req_c100", ref_req, 32'd1);
    check("pre_gnt_c100", gnt, 32'd1 << 2);
    @(posedge clk); #1;
    valid[2] = 1'b0;
    idle[2]  = 1'b1;
    @(negedge clk);
    check("ref_cycle_gnt_c101", gnt, 32'd0);
    check("pre_dfi_c101", {cs_n, ras_n, cas_n, we_n}, 4'b0010);
    check("pre_bank_c101", dbank, 32'd2);
    check("pre_addr_c101", daddr, 32'h102);
    @(posedge clk); #1;
    for (int c = 102; c < 127; c++) begin
      @(negedge clk);
      if (c == 102) begin
        check("ref_dfi_c102", {cs_n, ras_n, cas_n, we_n}, 4'b0001);
        check("ref_bank_hold_c102", dbank, 32'd2);
        check("ref_req_clr_c102", ref_req, 32'd0);
      end
      check($sformatf("trfc_block_c%0d", c), gnt, 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("act_after_trfc_c127", gnt, 32'd1 << 4);
    @(posedge clk); #1;
    valid[4] = 1'b0;
    @(negedge clk);
    check("act_dfi_c128", {cs_n, ras_n, cas_n, we_n}, 4'b0011);
    check("act_bank_c128", dbank, 32'd4);
    check("act_addr_c128", daddr, 32'h104);
    @(posedge clk); #1;

    // Test 6: refreshes starved until the owed count overflows
    reset_dut();
    idle = '0;
    repeat (899) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("ovf_c899", ref_ovf, 32'd0);
    check("ref_req_c899", ref_req, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("ovf_c900", ref_ovf, 32'd1);
    @(posedge clk); #1;
    idle = '1;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      done = !ref_req;
      @(posedge clk); #1;
    end
    check("ref_drained", done, 32'd1);
    check("ovf_sticky", ref_ovf, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("ovf_cleared_by_rst", ref_ovf, 32'd0);
    check("ref_req_cleared_by_rst", ref_req, 32'd0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
